// File: rtl/reveal_engine_pkg.sv
// Shared definitions for the minesweeper reveal sequencer.
//   cell_t          : board cell word {mine, flag, revealed, adj[3:0]}
//   reveal_state_e  : sequencer states
//   NB_DY / NB_DX   : neighbour offsets, scanned in row-major order
//   set_revealed    : returns a cell with its revealed bit forced on
//   is_fresh        : cell may be revealed (not mine, flag or revealed)
package buscaminas_pkg;

    localparam int GRID_N  = 8;
    localparam int COORD_W = 3;
    localparam int ADDR_W  = 6;
    localparam int CELLS   = GRID_N * GRID_N;
    localparam int CNT_W   = 7;

    localparam logic [CNT_W-1:0] CELLS_C = 7'd64;

    typedef struct packed {
        logic       mine;
        logic       flag;
        logic       revealed;
        logic [3:0] adj;
    } cell_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_TGT  = 3'd1,
        ST_CHK_TGT = 3'd2,
        ST_POP     = 3'd3,
        ST_NB_SEL  = 3'd4,
        ST_NB_CHK  = 3'd5,
        ST_DONE    = 3'd6
    } reveal_state_e;

    // (dy,dx) pairs: (-1,-1),(-1,0),(-1,1),(0,-1),(0,1),(1,-1),(1,0),(1,1)
    localparam logic signed [1:0] NB_DY [8] = '{2'sb11, 2'sb11, 2'sb11, 2'sb00,
                                                2'sb00, 2'sb01, 2'sb01, 2'sb01};
    localparam logic signed [1:0] NB_DX [8] = '{2'sb11, 2'sb00, 2'sb01, 2'sb11,
                                                2'sb01, 2'sb11, 2'sb00, 2'sb01};

    function automatic cell_t set_revealed(input cell_t c);
        cell_t r;
        r          = c;
        r.revealed = 1'b1;
        return r;
    endfunction

    function automatic logic is_fresh(input cell_t c);
        return !c.mine && !c.flag && !c.revealed;
    endfunction

endpackage

// File: rtl/reveal_engine_if.sv
// Board RAM port used by the reveal sequencer.
//   rd    : read strobe, data returns one cycle later on rdata
//   addr  : cell address {y, x}, shared by reads and writes
//   rdata : cell read back from the RAM
//   we    : write strobe
//   wdata : cell to write
// master = sequencer side, slave = RAM side.
interface reveal_engine_if;
    import buscaminas_pkg::*;

    logic              rd;
    logic [ADDR_W-1:0] addr;
    cell_t             rdata;
    logic              we;
    cell_t             wdata;

    modport master (output rd, addr, we, wdata, input rdata);
    modport slave  (input rd, addr, we, wdata, output rdata);
endinterface

// File: rtl/reveal_engine_stack.sv
// LIFO of cell addresses for the flood fill (GRID_N*GRID_N deep).
//   clk, reset   : clock, asynchronous active-low reset (empties the stack)
//   i_push       : push i_push_data
//   i_pop        : pop top entry; it appears on o_pop_data the next cycle
//   o_pop_data   : last popped address, held until the next pop
//   o_empty      : no entries stored
// Push and pop are never requested in the same cycle by the sequencer.
module reveal_stack
    import buscaminas_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_push_data,
    output logic [ADDR_W-1:0] o_pop_data,
    output logic              o_empty
);

    logic [ADDR_W-1:0] r_mem [CELLS];
    logic [ADDR_W:0]   r_ptr;
    logic [ADDR_W-1:0] r_pop_data;
    logic [ADDR_W-1:0] w_top;
    logic              w_full;

    assign w_top      = r_ptr[ADDR_W-1:0] - 6'd1;
    assign w_full     = r_ptr[ADDR_W];
    assign o_empty    = (r_ptr == 7'd0);
    assign o_pop_data = r_pop_data;

    // Storage array; contents need no reset because the pointer defines validity.
    always_ff @(posedge clk) begin
        if (i_push && !w_full) begin
            r_mem[r_ptr[ADDR_W-1:0]] <= i_push_data;
        end
    end

    // Stack pointer and registered pop data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr      <= 7'd0;
            r_pop_data <= 6'd0;
        end else if (i_push && !w_full) begin
            r_ptr <= r_ptr + 7'd1;
        end else if (i_pop && !o_empty) begin
            r_pop_data <= r_mem[w_top];
            r_ptr      <= r_ptr - 7'd1;
        end
    end

endmodule

// File: rtl/reveal_engine.sv
// Flood-fill reveal sequencer between the game FSM and the board RAM.
//   clk, reset        : clock, asynchronous active-low reset (aborts any operation)
//   start, sel_x/y    : select request and target cell (ignored while busy)
//   clear             : zero the running revealed total (ignored while busy)
//   num_mines         : mine count for the win check
//   mem               : board RAM port (master side)
//   busy, done        : operation in progress / one-cycle completion pulse
//   hit_mine          : last operation revealed a mine
//   last_count        : safe cells revealed by the last operation
//   total_revealed    : safe cells revealed since clear/reset
//   win               : total_revealed == 64 - num_mines
// A cell is marked revealed in the same cycle it is pushed, so it can never
// be pushed twice and the stack cannot overflow.
module reveal_engine
    import buscaminas_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] sel_x,
    input  logic [COORD_W-1:0] sel_y,
    input  logic               clear,
    input  logic [3:0]         num_mines,
    reveal_engine_if.master    mem,
    output logic               busy,
    output logic               done,
    output logic               hit_mine,
    output logic [CNT_W-1:0]   last_count,
    output logic [CNT_W-1:0]   total_revealed,
    output logic               win
);

    reveal_state_e     r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_tgt, w_tgt_nxt;
    logic [2:0]        r_nb_idx, w_nb_idx_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]  r_total, w_total_nxt;
    logic              r_hit, w_hit_nxt;
    logic              r_win, w_win_nxt;

    logic              w_rd, w_we, w_push, w_pop, w_empty;
    logic [ADDR_W-1:0] w_addr, w_push_data, w_ctr, w_nb_addr;
    logic [3:0]        w_nx, w_ny;
    logic              w_oob;
    cell_t             w_rcell;

    reveal_stack u_stack (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_push_data),
        .o_pop_data  (w_ctr),
        .o_empty     (w_empty)
    );

    assign w_rcell = mem.rdata;

    // Neighbour coordinate in 4 bits: -1 and 8 both set bit 3, so bit 3 flags out-of-bounds.
    assign w_nx      = {1'b0, w_ctr[2:0]} + {{2{NB_DX[r_nb_idx][1]}}, NB_DX[r_nb_idx]};
    assign w_ny      = {1'b0, w_ctr[5:3]} + {{2{NB_DY[r_nb_idx][1]}}, NB_DY[r_nb_idx]};
    assign w_oob     = w_nx[3] | w_ny[3];
    assign w_nb_addr = {w_ny[2:0], w_nx[2:0]};

    assign w_win_nxt = (w_total_nxt == (CELLS_C - {3'b000, num_mines}));

    // Next-state, datapath updates and RAM/stack strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_tgt_nxt    = r_tgt;
        w_nb_idx_nxt = r_nb_idx;
        w_cnt_nxt    = r_cnt;
        w_hit_nxt    = r_hit;
        w_total_nxt  = r_total;
        w_rd         = 1'b0;
        w_we         = 1'b0;
        w_addr       = r_tgt;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_push_data  = r_tgt;
        case (r_state)
            ST_IDLE: begin
                // clear applies before a same-cycle start is accepted
                if (clear) begin
                    w_total_nxt = 7'd0;
                end else begin
                    w_total_nxt = r_total;
                end
                if (start) begin
                    w_tgt_nxt   = {sel_y, sel_x};
                    w_cnt_nxt   = 7'd0;
                    w_hit_nxt   = 1'b0;
                    w_state_nxt = ST_RD_TGT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_TGT: begin
                w_rd        = 1'b1;
                w_state_nxt = ST_CHK_TGT;
            end
            ST_CHK_TGT: begin
                if (w_rcell.flag || w_rcell.revealed) begin
                    w_state_nxt = ST_DONE;
                end else if (w_rcell.mine) begin
                    w_we        = 1'b1;
                    w_hit_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_we      = 1'b1;
                    w_cnt_nxt = r_cnt + 7'd1;
                    if (w_rcell.adj == 4'd0) begin
                        w_push      = 1'b1;
                        w_state_nxt = ST_POP;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_POP: begin
                if (w_empty) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_pop        = 1'b1;
                    w_nb_idx_nxt = 3'd0;
                    w_state_nxt  = ST_NB_SEL;
                end
            end
            ST_NB_SEL: begin
                w_addr = w_nb_addr;
                if (w_oob) begin
                    if (r_nb_idx == 3'd7) begin
                        w_state_nxt = ST_POP;
                    end else begin
                        w_nb_idx_nxt = r_nb_idx + 3'd1;
                    end
                end else begin
                    w_rd        = 1'b1;
                    w_state_nxt = ST_NB_CHK;
                end
            end
            ST_NB_CHK: begin
                w_addr      = w_nb_addr;
                w_push_data = w_nb_addr;
                if (is_fresh(w_rcell)) begin
                    w_we      = 1'b1;
                    w_cnt_nxt = r_cnt + 7'd1;
                    if (w_rcell.adj == 4'd0) begin
                        w_push = 1'b1;
                    end else begin
                        w_push = 1'b0;
                    end
                end else begin
                    w_we = 1'b0;
                end
                if (r_nb_idx == 3'd7) begin
                    w_state_nxt = ST_POP;
                end else begin
                    w_nb_idx_nxt = r_nb_idx + 3'd1;
                    w_state_nxt  = ST_NB_SEL;
                end
            end
            ST_DONE: begin
                w_total_nxt = r_total + r_cnt;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_tgt    <= 6'd0;
            r_nb_idx <= 3'd0;
            r_cnt    <= 7'd0;
            r_total  <= 7'd0;
            r_hit    <= 1'b0;
            r_win    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tgt    <= w_tgt_nxt;
            r_nb_idx <= w_nb_idx_nxt;
            r_cnt    <= w_cnt_nxt;
            r_total  <= w_total_nxt;
            r_hit    <= w_hit_nxt;
            r_win    <= w_win_nxt;
        end
    end

    assign busy           = (r_state != ST_IDLE);
    assign done           = (r_state == ST_DONE);
    assign hit_mine       = r_hit;
    assign last_count     = r_cnt;
    assign total_revealed = r_total;
    assign win            = r_win;

    assign mem.rd    = w_rd;
    assign mem.we    = w_we;
    assign mem.addr  = w_addr;
    assign mem.wdata = set_revealed(mem.rdata);

endmodule
